// File: rtl/uart_rx_ctrl_pkg.sv
// Shared types and constants for the uart receive-path sequencer.
// Holds the FSM state encoding, data widths and the reset value of usr_options.
package uart_ctrl_pkg;

    localparam int BYTE_W         = 8;
    localparam int WORD_W         = 32;
    localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

    localparam logic [BYTE_W-1:0] DEFAULT_OPTIONS = 8'hC0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        ACK      = 2'd2,
        WAIT_CLR = 2'd3
    } rx_state_e;

    // Saturating increment for the parity-error counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// Byte handshake between the uart receiver (master) and the host-side sequencer (slave).
// new_data is a level held by the uart while data_in_nios/parity_status are valid; the
// sequencer answers each byte with data_read_nios high for exactly one cycle and then
// waits for new_data to fall before it will accept another byte.
interface uart_rx_ctrl_if;

    logic       new_data;
    logic [7:0] data_in_nios;
    logic       parity_status;
    logic       data_read_nios;

    modport master (
        output new_data,
        output data_in_nios,
        output parity_status,
        input  data_read_nios
    );

    modport slave (
        input  new_data,
        input  data_in_nios,
        input  parity_status,
        output data_read_nios
    );

endinterface

// File: rtl/uart_rx_ctrl_fifo.sv
// Synchronous first-word-fall-through byte FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module rx_byte_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_push_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_rd_data,
    output logic                       o_rd_valid,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_pop   = i_pop && !w_empty;
    assign w_push  = i_push && (!w_full || w_pop);

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    assign o_rd_data  = r_mem[r_rd_ptr];
    assign o_rd_valid = !w_empty;
    assign o_count    = r_count;
    assign o_full     = w_full;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Host-side uart receive sequencer: byte handshake FSM, options shadow register,
// parity screening, RX byte FIFO and 4-byte word assembly.
module uart_rx_ctrl
    import uart_ctrl_pkg::*;
#(
    parameter int                FIFO_DEPTH      = 8,
    parameter logic [BYTE_W-1:0] DEFAULT_OPTIONS = uart_ctrl_pkg::DEFAULT_OPTIONS,
    parameter int                DROP_BAD_PARITY = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [BYTE_W-1:0]            cfg_options,
    input  logic                         cfg_load,
    output logic [BYTE_W-1:0]            usr_options,
    uart_rx_ctrl_if.slave                uart,
    input  logic                         rd_en,
    output logic [BYTE_W-1:0]            rd_data,
    output logic                         rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic [7:0]                   parity_errs,
    output logic [WORD_W-1:0]            word_out,
    output logic                         word_valid,
    output rx_state_e                    dbg_state
);

    localparam bit DROP = (DROP_BAD_PARITY != 0);

    rx_state_e                 r_state;
    logic [BYTE_W-1:0]         r_pending;
    logic [BYTE_W-1:0]         r_usr_options;
    logic                      r_ack;
    logic                      r_overflow;
    logic [7:0]                r_parity_errs;
    logic [WORD_W-BYTE_W-1:0]  r_word_shift;
    logic [1:0]                r_byte_idx;
    logic [WORD_W-1:0]         r_word_out;
    logic                      r_word_valid;

    logic w_capture;
    logic w_keep;
    logic w_room;
    logic w_push;
    logic w_drop;
    logic w_fifo_full;

    assign w_capture = (r_state == CAPTURE);
    assign w_keep    = !(uart.parity_status && DROP);
    // A full FIFO still has room when the consumer pops on the same edge.
    assign w_room    = !w_fifo_full || rd_en;
    assign w_push    = w_capture && w_keep && w_room;
    assign w_drop    = w_capture && w_keep && !w_room;

    rx_byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BYTE_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .i_push      (w_push),
        .i_push_data (uart.data_in_nios),
        .i_pop       (rd_en),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_count     (fifo_count),
        .o_full      (w_fifo_full)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_pending     <= DEFAULT_OPTIONS;
            r_usr_options <= DEFAULT_OPTIONS;
            r_ack         <= 1'b0;
            r_overflow    <= 1'b0;
            r_parity_errs <= 8'd0;
            r_word_shift  <= '0;
            r_byte_idx    <= 2'd0;
            r_word_out    <= '0;
            r_word_valid  <= 1'b0;
        end else begin
            r_ack        <= 1'b0;
            r_word_valid <= 1'b0;
            if (cfg_load) begin
                r_pending <= cfg_options;
            end
            case (r_state)
                IDLE: begin
                    if (uart.new_data) begin
                        r_state <= CAPTURE;
                    end else begin
                        // Options only change between bytes; a same-cycle load wins.
                        r_usr_options <= cfg_load ? cfg_options : r_pending;
                    end
                end
                CAPTURE: begin
                    r_state <= ACK;
                    r_ack   <= 1'b1;
                    if (uart.parity_status) begin
                        r_parity_errs <= sat_inc8(r_parity_errs);
                    end
                    if (w_drop) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_push) begin
                        r_word_shift <= {r_word_shift[WORD_W-2*BYTE_W-1:0], uart.data_in_nios};
                        if (r_byte_idx == 2'(BYTES_PER_WORD - 1)) begin
                            r_word_out   <= {r_word_shift, uart.data_in_nios};
                            r_word_valid <= 1'b1;
                            r_byte_idx   <= 2'd0;
                        end else begin
                            r_byte_idx <= r_byte_idx + 2'd1;
                        end
                    end
                end
                ACK: begin
                    r_state <= WAIT_CLR;
                end
                WAIT_CLR: begin
                    if (!uart.new_data) begin
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign usr_options         = r_usr_options;
    assign uart.data_read_nios = r_ack;
    assign overflow            = r_overflow;
    assign parity_errs         = r_parity_errs;
    assign word_out            = r_word_out;
    assign word_valid          = r_word_valid;
    assign dbg_state           = r_state;

endmodule
